// File: rtl/picobello_link_buffer.sv
`default_nettype none
// ============================================================================
// Module  : picobello_link_buffer
// Purpose : Registered valid/ready link buffer with occupancy and idle status
// Rev     : 1.0
// ============================================================================
module picobello_link_buffer #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 2,
  parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic [CntWidth-1:0]  occupancy_o,
  output logic                 idle_o
);

  localparam int unsigned          c_PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [c_PTR_W-1:0]   c_LAST  = c_PTR_W'(Depth - 1);
  localparam logic [CntWidth-1:0]  c_FULL  = CntWidth'(Depth);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [c_PTR_W-1:0]   r_wp;
  logic [c_PTR_W-1:0]   r_rp;
  logic [CntWidth-1:0]  r_count;

  logic                 w_push;
  logic                 w_pop;
  logic [c_PTR_W-1:0]   w_wp_next;
  logic [c_PTR_W-1:0]   w_rp_next;

  // Ready comes only from the count register, so a pop on a full buffer
  // cannot open the input in the same cycle; this keeps ready registered.
  assign in_ready_o  = (r_count != c_FULL);
  assign out_valid_o = (r_count != '0);
  assign w_push      = in_valid_i && in_ready_o;
  assign w_pop       = out_valid_o && out_ready_i;

  assign w_wp_next = (r_wp == c_LAST) ? '0 : r_wp + c_PTR_W'(1);
  assign w_rp_next = (r_rp == c_LAST) ? '0 : r_rp + c_PTR_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wp <= w_wp_next;
      end
      if (w_pop) begin
        r_rp <= w_rp_next;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntWidth'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CntWidth'(1);
      end
    end
  end

  // Payload storage needs no reset; empty entries are masked at the output.
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) begin
      r_mem[r_wp] <= in_data_i;
    end
  end

  assign out_data_o  = out_valid_o ? r_mem[r_rp] : '0;
  assign occupancy_o = r_count;
  assign idle_o      = (r_count == '0) && !in_valid_i;

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    r_count <= c_FULL);
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_count == c_FULL) |-> !w_push);
  a_data_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i && !flush_i) |=> $stable(out_data_o));
`endif

endmodule
`default_nettype wire

// File: tb/tb_picobello_link_buffer.sv
`default_nettype none
// Bench for picobello_link_buffer: Depth 1, 2 and 3 instances against a queue model.
module tb_picobello_link_buffer;

  logic        clk;
  logic        rst;
  logic        vin   [3];
  logic        flush [3];
  logic        ordy  [3];
  logic [63:0] din   [3];
  logic        irdy  [3];
  logic        ovld  [3];
  logic        idle  [3];
  logic [63:0] dout  [3];
  logic [0:0]  occ1;
  logic [1:0]  occ2;
  logic [1:0]  occ3;
  logic [4:0]  occ   [3];

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mq [3][$];

  assign occ[0] = 5'(occ1);
  assign occ[1] = 5'(occ2);
  assign occ[2] = 5'(occ3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  picobello_link_buffer #(.DataWidth(64), .Depth(1)) u_d1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[0]),
    .in_valid_i(vin[0]), .in_ready_o(irdy[0]), .in_data_i(din[0]),
    .out_valid_o(ovld[0]), .out_ready_i(ordy[0]), .out_data_o(dout[0]),
    .occupancy_o(occ1), .idle_o(idle[0])
  );

  picobello_link_buffer #(.DataWidth(64), .Depth(2)) u_d2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[1]),
    .in_valid_i(vin[1]), .in_ready_o(irdy[1]), .in_data_i(din[1]),
    .out_valid_o(ovld[1]), .out_ready_i(ordy[1]), .out_data_o(dout[1]),
    .occupancy_o(occ2), .idle_o(idle[1])
  );

  picobello_link_buffer #(.DataWidth(64), .Depth(3)) u_d3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[2]),
    .in_valid_i(vin[2]), .in_ready_o(irdy[2]), .in_data_i(din[2]),
    .out_valid_o(ovld[2]), .out_ready_i(ordy[2]), .out_data_o(dout[2]),
    .occupancy_o(occ3), .idle_o(idle[2])
  );

  task automatic chk(input string nm, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, idx, $time, act, exp);
    end
  endtask

  function automatic int dep(input int k);
    return k + 1;
  endfunction

  function automatic logic rnd(input int pct);
    if (pct >= 100) return 1'b1;
    return ($urandom_range(99) < pct);
  endfunction

  // Reference: a FIFO of the accepted flits, updated once per clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) mq[k].delete();
    end else begin
      for (int k = 0; k < 3; k++) begin
        logic p_push, p_pop;
        p_push = vin[k] && (mq[k].size() != dep(k));
        p_pop  = (mq[k].size() != 0) && ordy[k];
        if (flush[k]) begin
          mq[k].delete();
        end else begin
          if (p_pop)  void'(mq[k].pop_front());
          if (p_push) mq[k].push_back(din[k]);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int sz;
      sz = mq[k].size();
      chk("in_ready",  k, 64'(irdy[k]), 64'(sz != dep(k)));
      chk("out_valid", k, 64'(ovld[k]), 64'(sz != 0));
      chk("out_data",  k, dout[k], (sz != 0) ? mq[k][0] : 64'h0);
      chk("occupancy", k, 64'(occ[k]), 64'(sz));
      chk("idle",      k, 64'(idle[k]), 64'((sz == 0) && !vin[k]));
    end
  end

  // Source holds each flit until accepted; sink checks the popped sequence.
  task automatic run_stream(input int k, input int n, input int pv, input int pr,
                            input int budget, output int cyc);
    int   pushed;
    int   popped;
    logic acc;
    pushed = 0;
    popped = 0;
    cyc    = 0;
    @(posedge clk); #2;
    vin[k]  = rnd(pv);
    din[k]  = 64'(pushed);
    ordy[k] = rnd(pr);
    while (popped < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (k == 0 && pv == 100 && pr == 100) chk("d1_ready_alt", k, 64'(irdy[0]), 64'(cyc % 2));
      if (k == 1 && pv == 100 && pushed < n) chk("d2_ready_high", k, 64'(irdy[1]), 64'd1);
      if (k == 2) chk("d3_count_max", k, 64'(occ[2] <= 5'd3), 64'd1);
      if (ovld[k] && ordy[k]) begin
        chk("seq", k, dout[k], 64'(popped));
        popped++;
      end
      acc = vin[k] && irdy[k];
      if (acc) pushed++;
      @(posedge clk); #2;
      if (!vin[k] || acc) begin
        vin[k] = (pushed < n) && rnd(pv);
        din[k] = 64'(pushed);
      end
      ordy[k] = rnd(pr);
    end
    if (popped < n) chk("stream_timeout", k, 64'(popped), 64'(n));
    vin[k]  = 1'b0;
    ordy[k] = 1'b0;
  endtask

  task automatic step(output logic dummy);
    @(negedge clk);
    @(posedge clk); #2;
    dummy = 1'b0;
  endtask

  initial begin
    int   cyc;
    logic d;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vin[k] = 1'b0; flush[k] = 1'b0; ordy[k] = 1'b0; din[k] = '0;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_ready", 1, 64'(irdy[1]), 64'd1);
    chk("rst_valid", 1, 64'(ovld[1]), 64'd0);
    chk("rst_occ",   1, 64'(occ2), 64'd0);
    chk("rst_idle",  1, 64'(idle[1]), 64'd1);
    chk("rst_data",  1, dout[1], 64'd0);

    // Single flit, latency one cycle
    @(posedge clk); #2;
    vin[1] = 1'b1; din[1] = 64'hA5; ordy[1] = 1'b1;
    @(negedge clk);
    chk("t1_occ0", 1, 64'(occ2), 64'd0);
    @(posedge clk); #2;
    vin[1] = 1'b0;
    @(negedge clk);
    chk("t1_valid", 1, 64'(ovld[1]), 64'd1);
    chk("t1_data",  1, dout[1], 64'hA5);
    chk("t1_occ1",  1, 64'(occ2), 64'd1);
    @(posedge clk); #2;
    @(negedge clk);
    chk("t1_occ2", 1, 64'(occ2), 64'd0);
    @(posedge clk); #2;
    ordy[1] = 1'b0;

    // Depth 2 full-throughput stream
    run_stream(1, 100, 100, 100, 400, cyc);
    chk("d2_cycles", 1, 64'(cyc), 64'd101);

    // Depth 2 backpressure, full buffer holds the third flit
    @(posedge clk); #2;
    vin[1] = 1'b1; din[1] = 64'h1;
    step(d); din[1] = 64'h2;
    step(d); din[1] = 64'h3;
    @(negedge clk);
    chk("t3_ready", 1, 64'(irdy[1]), 64'd0);
    chk("t3_occ",   1, 64'(occ2), 64'd2);
    chk("t3_head",  1, dout[1], 64'h1);
    @(posedge clk); #2;
    ordy[1] = 1'b1;
    @(negedge clk);
    chk("t3_pop_ready", 1, 64'(irdy[1]), 64'd0);
    @(posedge clk); #2;
    ordy[1] = 1'b0;
    @(negedge clk);
    chk("t3_occ_after_pop", 1, 64'(occ2), 64'd1);
    chk("t3_head2", 1, dout[1], 64'h2);
    chk("t3_ready2", 1, 64'(irdy[1]), 64'd1);
    @(posedge clk); #2;
    vin[1] = 1'b0;
    @(negedge clk);
    chk("t3_occ_refill", 1, 64'(occ2), 64'd2);
    @(posedge clk); #2;
    ordy[1] = 1'b1;
    @(negedge clk);
    chk("t3_out2", 1, dout[1], 64'h2);
    @(negedge clk);
    chk("t3_out3", 1, dout[1], 64'h3);
    @(negedge clk);
    chk("t3_empty", 1, 64'(ovld[1]), 64'd0);
    @(posedge clk); #2;
    ordy[1] = 1'b0;

    // Depth 1 half throughput
    run_stream(0, 10, 100, 100, 100, cyc);
    chk("d1_cycles", 0, 64'(cyc), 64'd20);

    // Depth 3 random handshakes
    run_stream(2, 1000, 50, 50, 20000, cyc);

    // Flush with two flits stored and an input valid
    @(posedge clk); #2;
    vin[1] = 1'b1; din[1] = 64'h31;
    step(d); din[1] = 64'h32;
    step(d); din[1] = 64'h77; flush[1] = 1'b1;
    @(negedge clk);
    chk("fl_occ_before", 1, 64'(occ2), 64'd2);
    @(posedge clk); #2;
    flush[1] = 1'b0; vin[1] = 1'b0;
    @(negedge clk);
    chk("fl_occ",   1, 64'(occ2), 64'd0);
    chk("fl_valid", 1, 64'(ovld[1]), 64'd0);
    chk("fl_data",  1, dout[1], 64'd0);

    // Flush discards a push that would otherwise be accepted
    @(posedge clk); #2;
    vin[1] = 1'b1; din[1] = 64'h41;
    step(d); din[1] = 64'h42; flush[1] = 1'b1;
    @(posedge clk); #2;
    flush[1] = 1'b0; vin[1] = 1'b0;
    @(negedge clk);
    chk("fl2_occ",   1, 64'(occ2), 64'd0);
    chk("fl2_valid", 1, 64'(ovld[1]), 64'd0);

    // Asynchronous reset mid-stream
    @(posedge clk); #2;
    vin[2] = 1'b1; din[2] = 64'h11;
    step(d); din[2] = 64'h22;
    step(d); vin[2] = 1'b0;
    @(negedge clk);
    chk("ar_occ_before", 2, 64'(occ3), 64'd2);
    chk("ar_head", 2, dout[2], 64'h11);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("ar_occ",   2, 64'(occ3), 64'd0);
    chk("ar_valid", 2, 64'(ovld[2]), 64'd0);
    chk("ar_ready", 2, 64'(irdy[2]), 64'd1);
    chk("ar_data",  2, dout[2], 64'd0);
    chk("ar_idle",  2, 64'(idle[2]), 64'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/picobello_link_buffer.md
Name: picobello_link_buffer

Overview:
Elastic valid/ready retiming buffer for one NoC link direction (req, rsp or wide), placed on the wire between one tile's floo output and the neighbouring tile's floo input in the mesh.
- Cuts every combinational path across the tile boundary: data, valid and ready are all registered.
- Sustains full throughput with Depth >= 2.
- Reports occupancy and idleness for link-activity monitoring.
- The top level instantiates one per channel per non-tied-off mesh edge when link pipelining is enabled.

Parameters:
DataWidth, 64, width of the flit payload (req/rsp/wide flit struct width minus handshake bits).
Depth, 2, number of buffer entries; legal range 1..16; Depth=1 gives half throughput.
CntWidth, $clog2(Depth+1), width of the occupancy output (derived, not overridden).

Ports:
clk_i  input  1  clock.
rst_i  input  1  asynchronous active-high reset.
flush_i  input  1  synchronous clear of all entries (test/debug use only).
in_valid_i  input  1  upstream flit valid.
in_ready_o  output  1  buffer can accept a flit.
in_data_i  input  DataWidth  upstream flit payload.
out_valid_o  output  1  flit available downstream.
out_ready_i  input  1  downstream accepts the flit.
out_data_o  output  DataWidth  head flit payload.
occupancy_o  output  CntWidth  number of stored flits.
idle_o  output  1  buffer empty and no input valid.

Behaviour:
- One clock domain; reset asserted asynchronously, released synchronously to clk_i by the integrator.
- Reset values:
  - in_ready_o=1, out_valid_o=0, occupancy_o=0, idle_o=1 (if in_valid_i=0).
  - Read/write pointers = 0.
  - out_data_o = 0; storage contents are don't-care.
- Storage: circular array of Depth entries with write pointer wp and read pointer rp.
  - Each pointer wraps from Depth-1 to 0; no power-of-two restriction.
  - A count register of CntWidth bits tracks fill level.
- Push: in_valid_i && in_ready_o at a rising edge writes in_data_i to entry wp, then advances wp.
- Pop: out_valid_o && out_ready_i at a rising edge advances rp.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Ready path: in_ready_o = (count != Depth), driven from registered state only. It has no combinational dependence on out_ready_i.
  - When full, a same-cycle pop does NOT allow a same-cycle push; the push is accepted one cycle later.
- Output path:
  - out_valid_o = (count != 0).
  - out_data_o = entry[rp] when valid, 0 when empty.
  - No fall-through: a flit written at edge N is first visible at out_valid_o after edge N. Minimum latency is 1 cycle.
- Throughput:
  - Depth >= 2: one flit per cycle sustained under continuous in_valid_i and out_ready_i.
  - Depth = 1: one flit every 2 cycles.
- Valid/ready protocol:
  - While out_valid_o=1 and out_ready_i=0, out_data_o stays stable.
  - out_valid_o never deasserts without a pop.
  - Upstream is required to hold in_valid_i/in_data_i stable until accepted. The buffer does not check this.
- flush_i: at the next edge, count, wp and rp become 0 and any same-cycle push or pop is discarded. Flush has priority over push and pop.
- occupancy_o = count (registered).
- idle_o = (count == 0) && !in_valid_i. This is the only combinational input-to-output path.
- Reset mid-operation: all stored flits are lost and outputs return to reset values immediately (asynchronous).
- Assertions (simulation only):
  - count <= Depth.
  - No push when in_ready_o=0.
  - out_data_o stable while stalled.

Test Plan:
- Reset, then push 0xA5 at cycle 1 with out_ready_i=1 -> out_valid_o=1 and out_data_o=0xA5 in cycle 2, popped at end of cycle 2; occupancy_o sequence 0,1,0.
- Depth=2, stream 100 incrementing flits with in_valid_i and out_ready_i held high -> 100 flits out in order, one per cycle after 1-cycle latency, in_ready_o never drops.
- Depth=2, out_ready_i=0, push 0x1,0x2,0x3 -> 0x1 and 0x2 accepted, in_ready_o=0 with 0x3 held, occupancy_o=2. Raise out_ready_i for one cycle -> 0x1 popped, 0x3 accepted the following cycle, order 0x1,0x2,0x3 preserved.
- Depth=1, continuous traffic of 10 flits -> 20 cycles to drain, alternating in_ready_o; data order intact.
- Depth=3, random valid/ready (50% each) for 1000 flits with scoreboard -> no loss or duplication; pointer wrap at 2->0 exercised; count never exceeds 3.
- With 2 flits stored, assert flush_i together with in_valid_i=1 -> next cycle occupancy_o=0, out_valid_o=0, pushed flit discarded. Separately, assert rst_i mid-stream -> outputs return to reset values without waiting for a clock edge.
